wta_rank_core: RTL

- Parameterised successor of the 8-channel PWM fall-detect / k-NN search path.
- Times N_CH PWM channels against a common frame counter and captures each channel's pulse width.
- Ranks channels by fall order and reports the winner (nearest neighbour) mask, the k-winners mask and the winner index.
- Frame-based start/valid handshake, timeout and tie handling; sits between the PWM input switches and the SPI readback registers.

---
 rtl/wta_pkg.sv | 16 +
 rtl/wta_fall_det.sv | 30 +++
 rtl/wta_rank_core.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/wta_pkg.sv
// wta_rank_core shared types and constants.
// Optional early stop is selected with WTA_EARLY_STOP_EN.
package wta_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_e;

    localparam int SYNC_STAGES = 2;

    // Width reported by a channel that has not fallen this frame.
    localparam logic [31:0] WIDTH_NONE = '1;

endpackage

// File: rtl/wta_fall_det.sv
// Per-channel PWM synchroniser and falling-edge pulse generator.
// The fall pulse is registered and appears 3 clocks after the input edge.
module wta_fall_det
    import wta_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic i_pwm,
    output logic o_fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic                   fall_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
            prev_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], i_pwm};
            prev_q <= sync_q[SYNC_STAGES-1];
            fall_q <= prev_q & ~sync_q[SYNC_STAGES-1];
        end
    end

    assign o_fall = fall_q;

endmodule

// File: rtl/wta_rank_core.sv
// Winner-take-all fall-order ranking of N_CH PWM channels per frame.
// Define WTA_EARLY_STOP_EN to end a frame once i_k channels have fallen.
module wta_rank_core
    import wta_pkg::*;
#(
    parameter int N_CH  = 8,
    parameter int CNT_W = 12,
    parameter int IDX_W = $clog2(N_CH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_start,
    input  logic [N_CH-1:0]       i_pwm,
    input  logic [IDX_W:0]        i_k,
    input  logic [CNT_W-1:0]      i_timeout,
    output logic                  o_busy,
    output logic                  o_valid,
    output logic [N_CH-1:0]       o_nn,
    output logic [N_CH-1:0]       o_knn,
    output logic [IDX_W-1:0]      o_nn_idx,
    output logic [IDX_W:0]        o_fall_cnt,
    output logic [N_CH*CNT_W-1:0] o_width
);

    localparam int KW = IDX_W + 1;
    localparam logic [CNT_W-1:0] W_NONE = WIDTH_NONE[CNT_W-1:0];

    logic [N_CH-1:0] fall;

    for (genvar g = 0; g < N_CH; g++) begin : g_det
        wta_fall_det u_det (
            .clk   (clk),
            .rst   (rst),
            .i_pwm (i_pwm[g]),
            .o_fall(fall[g])
        );
    end

    state_e                     state_q, state_d;
    logic [CNT_W-1:0]           cnt_q, cnt_d;
    logic [N_CH-1:0]            fallen_q, fallen_d;
    logic [N_CH-1:0][KW-1:0]    rank_q, rank_d;
    logic [N_CH-1:0][CNT_W-1:0] width_q, width_d;
    logic [KW-1:0]              fcnt_q, fcnt_d;
    logic [KW-1:0]              n_new;
    logic [N_CH-1:0]            new_fall;
    logic                       clear, tmo_hit, early, commit;

    logic [N_CH-1:0]  nn_m, knn_m, nn_q, knn_q;
    logic [IDX_W-1:0] idx_m, idx_q;
    logic [KW-1:0]    fc_q;
    logic             valid_q;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        fallen_d = fallen_q;
        rank_d   = rank_q;
        width_d  = width_q;
        fcnt_d   = fcnt_q;
        clear    = 1'b0;
        new_fall = '0;
        n_new    = '0;
        early    = 1'b0;
        tmo_hit  = (cnt_q == i_timeout);
        unique case (state_q)
            IDLE: begin
                if (i_start) begin
                    clear   = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (i_start) begin
                    clear = 1'b1;
                end else begin
                    cnt_d = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
                    if (!tmo_hit) new_fall = fall & ~fallen_q;
                    // Same-cycle falls share the rank of the count before them.
                    for (int i = 0; i < N_CH; i++) begin
                        if (new_fall[i]) begin
                            fallen_d[i] = 1'b1;
                            rank_d[i]   = fcnt_q;
                            width_d[i]  = cnt_q;
                            n_new       = n_new + 1'b1;
                        end
                    end
                    fcnt_d = fcnt_q + n_new;
`ifdef WTA_EARLY_STOP_EN
                    early = (i_k != '0) && (fcnt_d >= i_k);
`else
                    early = 1'b0;
`endif
                    if (tmo_hit || (&fallen_d) || early) state_d = DONE;
                end
            end
            DONE: begin
                if (i_start) begin
                    clear   = 1'b1;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (clear) begin
            cnt_d    = '0;
            fallen_d = '0;
            rank_d   = '0;
            fcnt_d   = '0;
            for (int i = 0; i < N_CH; i++) width_d[i] = W_NONE;
        end
    end

    // Masks use next-state flags so a fall on the final RUN cycle counts.
    always_comb begin
        nn_m  = '0;
        knn_m = '0;
        idx_m = '0;
        for (int i = 0; i < N_CH; i++) begin
            nn_m[i]  = fallen_d[i] && (rank_d[i] == '0);
            knn_m[i] = fallen_d[i] && (rank_d[i] < i_k);
        end
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (nn_m[i]) idx_m = IDX_W'(i);
        end
    end

    assign commit = (state_q == RUN) && (state_d == DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            fallen_q <= '0;
            rank_q   <= '0;
            width_q  <= {N_CH{W_NONE}};
            fcnt_q   <= '0;
            valid_q  <= 1'b0;
            nn_q     <= '0;
            knn_q    <= '0;
            idx_q    <= '0;
            fc_q     <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            fallen_q <= fallen_d;
            rank_q   <= rank_d;
            width_q  <= width_d;
            fcnt_q   <= fcnt_d;
            valid_q  <= commit;
            if (commit) begin
                nn_q  <= nn_m;
                knn_q <= knn_m;
                idx_q <= idx_m;
                fc_q  <= fcnt_d;
            end
        end
    end

    assign o_busy     = (state_q == RUN);
    assign o_valid    = valid_q;
    assign o_nn       = nn_q;
    assign o_knn      = knn_q;
    assign o_nn_idx   = idx_q;
    assign o_fall_cnt = fc_q;
    assign o_width    = width_q;

endmodule
